// File: rtl/srt4_otf_converter.sv
// Radix-4 SRT quotient-digit consumer with on-the-fly conversion.
// Digits {-2..+2} are folded into the Q / QM register pair (QM = Q-1 mod 2^W),
// so no carry-propagate adder is needed. After the last digit the final
// remainder sign selects Q or QM as the corrected binary quotient.
//
// Handshake: a digit transfers on a rising edge where q_valid && q_ready and
// start is low; q_ready is high only while accumulating. rem_valid is only
// looked at while waiting for the remainder sign, and start always wins.
module srt4_otf_converter #(
  parameter  int NDIG = 8,
  localparam int W    = 2 * NDIG,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         q_valid,
  input  logic [2:0]   q_digit,
  output logic         q_ready,
  input  logic         rem_valid,
  input  logic         rem_neg,
  output logic [W-1:0] quot,
  output logic         done,
  output logic         busy,
  output logic         err,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_WAIT_REM = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  q_reg, qm_reg;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last_digit;
  logic          digit_illegal;
  logic          q_from_qm;   // digit negative: new Q is built from QM
  logic          qm_from_q;   // digit positive: new QM is built from Q
  logic [1:0]    q_low;
  logic [1:0]    qm_low;

  assign q_ready    = (state == S_ACCUM);
  assign busy       = (state == S_ACCUM) || (state == S_WAIT_REM);
  assign state_dbg  = state;
  assign accept     = q_valid && q_ready && !start;
  assign last_digit = (cnt == CW'(NDIG - 1));

  // Decode the sign-magnitude digit into the two appended radix-4 slices.
  // Illegal codes behave exactly like a zero digit.
  always_comb begin
    digit_illegal = 1'b0;
    q_from_qm     = 1'b0;
    qm_from_q     = 1'b0;
    q_low         = 2'b00;
    qm_low        = 2'b11;
    case (q_digit)
      3'b000: begin q_low = 2'b00; qm_low = 2'b11; end
      3'b001: begin q_low = 2'b01; qm_low = 2'b00; qm_from_q = 1'b1; end
      3'b010: begin q_low = 2'b10; qm_low = 2'b01; qm_from_q = 1'b1; end
      3'b101: begin q_low = 2'b11; qm_low = 2'b10; q_from_qm = 1'b1; end
      3'b110: begin q_low = 2'b10; qm_low = 2'b01; q_from_qm = 1'b1; end
      default: digit_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_ACCUM;
    end else begin
      case (state)
        S_ACCUM:    if (accept && last_digit) state_next = S_WAIT_REM;
        S_WAIT_REM: if (rem_valid)            state_next = S_DONE;
        default:    state_next = state;
      endcase
    end
  end

  // Accumulators, digit counter, sticky error and the corrected result.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= '0;
      qm_reg <= '1;
      cnt    <= '0;
      quot   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q_reg  <= '0;
        qm_reg <= '1;
        cnt    <= '0;
        err    <= 1'b0;
      end else begin
        if (accept) begin
          q_reg  <= q_from_qm ? {qm_reg[W-3:0], q_low}  : {q_reg[W-3:0], q_low};
          qm_reg <= qm_from_q ? {q_reg[W-3:0], qm_low}  : {qm_reg[W-3:0], qm_low};
          if (!last_digit) cnt <= cnt + 1'b1;
          if (digit_illegal) err <= 1'b1;
        end
        if (state == S_WAIT_REM && rem_valid) begin
          quot <= rem_neg ? qm_reg : q_reg;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_srt4_otf_converter.sv
// Bench for srt4_otf_converter: directed cases plus random legal digit streams,
// checked against an arithmetic model (sum of d_i*4^k minus remainder sign).
module tb_srt4_otf_converter;
  localparam int NDIG = 8;
  localparam int W    = 2 * NDIG;

  logic         clk = 1'b0;
  logic         rst, start, q_valid, rem_valid, rem_neg;
  logic [2:0]   q_digit;
  logic         q_ready, done, busy, err;
  logic [W-1:0] quot;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q;
  bit           err_exp;
  bit           noise;
  logic [2:0]   cur_codes [NDIG];
  logic [2:0]   legal_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

  srt4_otf_converter #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .start(start), .q_valid(q_valid), .q_digit(q_digit),
    .q_ready(q_ready), .rem_valid(rem_valid), .rem_neg(rem_neg), .quot(quot),
    .done(done), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model
  function automatic int dval(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b101:  return -1;
      3'b110:  return -2;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b100) || (c == 3'b111);
  endfunction

  function automatic logic [W-1:0] ref_quot(input bit rn);
    longint acc = 0;
    for (int i = 0; i < NDIG; i++) acc = acc * 4 + longint'(dval(cur_codes[i]));
    acc = acc - (rn ? 64'sd1 : 64'sd0);
    return acc[W-1:0];
  endfunction

  // Monitor: every done pulse consumes one expected quotient.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done quot=0x%0h", quot);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("quot", 32'(quot), 32'(e));
      end
    end
  end

  // Driver tasks: each is entered and left on a falling edge.
  task automatic load4(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] d);
    for (int i = 0; i < NDIG - 4; i++) cur_codes[i] = 3'b000;
    cur_codes[NDIG-4] = a;
    cur_codes[NDIG-3] = b;
    cur_codes[NDIG-2] = c;
    cur_codes[NDIG-1] = d;
  endtask

  task automatic start_pulse();
    start = 1'b1; q_valid = 1'b0; rem_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    err_exp = 1'b0;
    check("quot_held_after_start", 32'(quot), 32'(last_q));
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_digit(input logic [2:0] code, input int gap);
    repeat (gap) begin
      q_valid = 1'b0;
      rem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check("err_running", 32'(err), 32'(err_exp));
    check("q_ready_accum", 32'(q_ready), 32'd1);
    q_valid = 1'b1;
    q_digit = code;
    rem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    q_valid = 1'b0;
    rem_valid = 1'b0;
    if (is_illegal(code)) err_exp = 1'b1;
  endtask

  task automatic send_all(input int gap);
    for (int i = 0; i < NDIG; i++) send_digit(cur_codes[i], gap);
  endtask

  task automatic finish(input bit rn, input logic [W-1:0] expv);
    check("q_ready_wait_rem", 32'(q_ready), 32'd0);
    check("busy_wait_rem", 32'(busy), 32'd1);
    check("state_wait_rem", 32'(state_dbg), 32'd2);
    rem_valid = 1'b1;
    rem_neg = rn;
    exp_q.push_back(expv);
    @(negedge clk);
    rem_valid = 1'b0;
    check("done_latency", 32'(done), 32'd1);
    check("err_final", 32'(err), 32'(err_exp));
    check("busy_done", 32'(busy), 32'd0);
    last_q = expv;
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; start = 1'b0; q_valid = 1'b0; q_digit = 3'b000;
    rem_valid = 1'b0; rem_neg = 1'b0; noise = 1'b0; err_exp = 1'b0;
    last_q = '0;
    repeat (3) @(negedge clk);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_q_ready", 32'(q_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // +2,+1,0,-1 with both remainder signs
    load4(3'b010, 3'b001, 3'b000, 3'b101);
    start_pulse(); send_all(0); finish(1'b0, 16'h008F);
    start_pulse(); send_all(0); finish(1'b1, 16'h008E);

    // -2,+2,+2,+2 -> -86
    load4(3'b110, 3'b010, 3'b010, 3'b010);
    start_pulse(); send_all(0); finish(1'b0, 16'hFFAA);

    // all zero, negative remainder, with gaps of 3 idle cycles
    load4(3'b000, 3'b000, 3'b000, 3'b000);
    start_pulse(); send_all(3); finish(1'b1, 16'hFFFF);

    // illegal digit in position 2
    load4(3'b001, 3'b011, 3'b001, 3'b001);
    start_pulse(); send_all(0); finish(1'b0, 16'h0045);
    check("err_sticky_in_done", 32'(err), 32'd1);

    // abort after two digits by restarting
    load4(3'b001, 3'b001, 3'b001, 3'b001);
    start_pulse();
    send_digit(3'b010, 0);
    send_digit(3'b110, 0);
    start_pulse(); send_all(0); finish(1'b0, 16'h0055);

    // reset while waiting for the remainder sign: no done may follow
    start_pulse(); send_all(0);
    check("state_before_rst", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_quot", 32'(quot), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_q_ready", 32'(q_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    last_q = '0;
    rem_valid = 1'b1; rem_neg = 1'b0;
    repeat (2) @(negedge clk);
    rem_valid = 1'b0;
    check("idle_ignores_rem_valid", 32'(done), 32'd0);

    // random legal streams, with idle gaps and stray rem_valid while accumulating
    noise = 1'b1;
    for (int run = 0; run < 1000; run++) begin
      bit rn;
      int gap;
      for (int i = 0; i < NDIG; i++) cur_codes[i] = legal_tab[$urandom_range(0, 4)];
      rn  = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      start_pulse();
      send_all(gap);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      finish(rn, ref_quot(rn));
    end
    noise = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
